// File: rtl/jpeg_stream_pkg.sv
// jpeg_stream_pkg
//   Shared definitions for the JPEG coefficient stream sink:
//   channel tag values carried on tuser, the framing FSM state encoding,
//   and the default number of beats per channel.
package jpeg_stream_pkg;

   localparam int PIXEL_COUNT_DEF = 64;

   localparam logic [1:0] CH_Y  = 2'b00;
   localparam logic [1:0] CH_CB = 2'b01;
   localparam logic [1:0] CH_CR = 2'b10;

   typedef enum logic [1:0] {
      RECV    = 2'b00,
      DISCARD = 2'b01,
      FULL    = 2'b10
   } state_t;

endpackage

// File: rtl/coeff_block_ram.sv
// coeff_block_ram
//   One-write / one-read synchronous RAM holding a Y/Cb/Cr coefficient block.
//   Ports:
//     clk, reset_n   clock, synchronous active-low reset (read register only)
//     we_i           write enable
//     waddr_i        write address
//     wdata_i        write data
//     raddr_i        read address; addresses >= DEPTH read back as zero
//     rdata_o        registered read data, one-cycle latency
//   The array itself is never reset so it can map onto block or distributed RAM.
module coeff_block_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int DEPTH      = 192
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rdata_q <= '0;
      end else if ({1'b0, raddr_i} < DEPTH_W) begin
         rdata_q <= mem_q[raddr_i];
      end else begin
         rdata_q <= '0;
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/jpeg_coeff_stream_sink.sv
// jpeg_coeff_stream_sink
//   AXI-Stream sink for the JPEG coefficient stream. Checks Y/Cb/Cr framing
//   (tuser tag and tlast position), buffers one complete block and holds it
//   for a reader until blk_release.
//   Handshake: a beat transfers on a rising edge where s_axis_tvalid and
//   s_axis_tready are both high; tready is registered and drops while a full
//   block is held.
//   Ports:
//     s_axis_*     coefficient stream input (tdata/tvalid/tready/tlast/tuser)
//     blk_ready    a complete block is held in the buffer
//     blk_done     one-cycle pulse on block completion
//     blk_release  reader frees the buffer (only acted on while full)
//     rd_addr/rd_data  read port, address ch*PIXEL_COUNT+idx, one-cycle latency
//     err_chan/err_len sticky framing errors, cleared by clr_err (set wins)
//     blk_count    completed block counter, wraps
//     dbg_state    current framing FSM state
module jpeg_coeff_stream_sink
   import jpeg_stream_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int DATA_DEPTH  = 8,
   parameter int PIXEL_COUNT = DATA_DEPTH * DATA_DEPTH,
   parameter int ADDR_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   input  logic [1:0]            s_axis_tuser,
   output logic                  blk_ready,
   output logic                  blk_done,
   input  logic                  blk_release,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  err_chan,
   output logic                  err_len,
   input  logic                  clr_err,
   output logic [15:0]           blk_count,
   output logic [1:0]            dbg_state
);

   localparam int               IDX_W    = $clog2(PIXEL_COUNT);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PIXEL_COUNT - 1);

   state_t             state_q, state_d;
   logic [1:0]         ch_q, ch_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               tready_q, tready_d;
   logic               blk_done_q, blk_done_d;
   logic [15:0]        blk_count_q, blk_count_d;
   logic               err_chan_q, err_chan_d;
   logic               err_len_q, err_len_d;

   logic                  beat;
   logic                  set_chan;
   logic                  set_len;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;

   assign beat    = s_axis_tvalid & tready_q;
   assign wr_addr = ADDR_WIDTH'(ch_q * PIXEL_COUNT) + ADDR_WIDTH'(idx_q);

   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      idx_d       = idx_q;
      blk_done_d  = 1'b0;
      blk_count_d = blk_count_q;
      set_chan    = 1'b0;
      set_len     = 1'b0;
      wr_en       = 1'b0;

      case (state_q)
         RECV: begin
            if (beat) begin
               if ((s_axis_tuser != ch_q) || (s_axis_tuser == 2'b11)) begin
                  // Wrong tag: drop the block; if the channel is still open,
                  // skip the rest of it so we resync on its tlast.
                  set_chan = 1'b1;
                  ch_d     = CH_Y;
                  idx_d    = '0;
                  if (!s_axis_tlast) state_d = DISCARD;
               end else if (s_axis_tlast && (idx_q != IDX_LAST)) begin
                  // Short channel: tlast already closed it, restart on Y.
                  set_len = 1'b1;
                  ch_d    = CH_Y;
                  idx_d   = '0;
               end else if (!s_axis_tlast && (idx_q == IDX_LAST)) begin
                  // Long channel: wait for the tlast that actually ends it.
                  set_len = 1'b1;
                  ch_d    = CH_Y;
                  idx_d   = '0;
                  state_d = DISCARD;
               end else begin
                  wr_en = 1'b1;
                  if (idx_q != IDX_LAST) begin
                     idx_d = idx_q + IDX_W'(1);
                  end else if (ch_q != CH_CR) begin
                     ch_d  = ch_q + 2'd1;
                     idx_d = '0;
                  end else begin
                     ch_d        = CH_Y;
                     idx_d       = '0;
                     state_d     = FULL;
                     blk_done_d  = 1'b1;
                     blk_count_d = blk_count_q + 16'd1;
                  end
               end
            end
         end
         DISCARD: begin
            if (beat && s_axis_tlast) begin
               state_d = RECV;
               ch_d    = CH_Y;
               idx_d   = '0;
            end
         end
         FULL: begin
            if (blk_release) begin
               state_d = RECV;
               ch_d    = CH_Y;
               idx_d   = '0;
            end
         end
         default: begin
            state_d = RECV;
            ch_d    = CH_Y;
            idx_d   = '0;
         end
      endcase

      // Set has priority over clear so a coincident error is never lost.
      err_chan_d = (err_chan_q & ~clr_err) | set_chan;
      err_len_d  = (err_len_q & ~clr_err) | set_len;
      tready_d   = (state_d != FULL);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= RECV;
         ch_q        <= CH_Y;
         idx_q       <= '0;
         tready_q    <= 1'b0;
         blk_done_q  <= 1'b0;
         blk_count_q <= '0;
         err_chan_q  <= 1'b0;
         err_len_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         idx_q       <= idx_d;
         tready_q    <= tready_d;
         blk_done_q  <= blk_done_d;
         blk_count_q <= blk_count_d;
         err_chan_q  <= err_chan_d;
         err_len_q   <= err_len_d;
      end
   end

   coeff_block_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (3 * PIXEL_COUNT)
   ) u_ram (
      .clk     (clk),
      .reset_n (reset_n),
      .we_i    (wr_en),
      .waddr_i (wr_addr),
      .wdata_i (s_axis_tdata),
      .raddr_i (rd_addr),
      .rdata_o (rd_data)
   );

   assign s_axis_tready = tready_q;
   assign blk_ready     = (state_q == FULL);
   assign blk_done      = blk_done_q;
   assign blk_count     = blk_count_q;
   assign err_chan      = err_chan_q;
   assign err_len       = err_len_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_jpeg_coeff_stream_sink.sv
// tb_jpeg_coeff_stream_sink
//   Stream stimulus with directed framing errors and random blocks. A
//   reference model tracks the stream as a queue of accepted words; whenever
//   it sees a completed block it queues the expected count and contents,
//   which a monitor checks on blk_done by reading the whole buffer back.
module tb_jpeg_coeff_stream_sink;
   import jpeg_stream_pkg::*;

   localparam int PC  = 64;
   localparam int BLK = 3 * PC;

   localparam int K_GOOD  = 0;
   localparam int K_CHAN  = 1;
   localparam int K_EARLY = 2;
   localparam int K_MISS  = 3;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] s_axis_tdata = '0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic        s_axis_tlast = 1'b0;
   logic [1:0]  s_axis_tuser = '0;
   logic        blk_ready;
   logic        blk_done;
   logic        blk_release = 1'b0;
   logic [7:0]  rd_addr = '0;
   logic [31:0] rd_data;
   logic        err_chan;
   logic        err_len;
   logic        clr_err = 1'b0;
   logic [15:0] blk_count;
   logic [1:0]  dbg_state;

   always #5 clk = ~clk;

   jpeg_coeff_stream_sink dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tuser  (s_axis_tuser),
      .blk_ready     (blk_ready),
      .blk_done      (blk_done),
      .blk_release   (blk_release),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .err_chan      (err_chan),
      .err_len       (err_len),
      .clr_err       (clr_err),
      .blk_count     (blk_count),
      .dbg_state     (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int tests = 0;
   int fails = 0;

   logic [31:0] exp_q[$];      // expected buffer words, BLK per completed block
   logic [15:0] exp_cnt_q[$];  // expected blk_count per completed block
   int          rb_count = 0;  // readbacks finished by the monitor
   int          rb_seen  = 0;

   // Reference model: words accepted so far for the block being assembled.
   logic [31:0] cur_q[$];
   bit          m_discarding = 1'b0;
   bit          m_full = 1'b0;
   bit          m_err_chan = 1'b0;
   bit          m_err_len = 1'b0;
   int          m_count = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // A block is three runs of PC words tagged Y, Cb, Cr, each closed by tlast
   // exactly on its last word; anything else drops the partial block, and a
   // run left open is skipped through its next tlast.
   function automatic void model_beat(input logic [31:0] d, input logic [1:0] u,
                                      input logic l, input logic c);
      int pos;
      int ch;
      int idx;
      if (c) begin
         m_err_chan = 1'b0;
         m_err_len  = 1'b0;
      end
      if (m_discarding) begin
         if (l) m_discarding = 1'b0;
         return;
      end
      pos = cur_q.size();
      ch  = pos / PC;
      idx = pos % PC;
      if (int'(u) != ch) begin
         m_err_chan = 1'b1;
         cur_q.delete();
         m_discarding = !l;
      end else if (l != (idx == PC - 1)) begin
         m_err_len = 1'b1;
         cur_q.delete();
         m_discarding = !l;
      end else begin
         cur_q.push_back(d);
         if (cur_q.size() == BLK) begin
            m_count++;
            exp_cnt_q.push_back(16'(m_count));
            foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
            cur_q.delete();
            m_full = 1'b1;
         end
      end
   endfunction

   // ---------------- monitor ----------------
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (reset_n && blk_done) begin
            if (exp_cnt_q.size() == 0) begin
               check("unexpected_blk_done", 32'(blk_done), 32'd0);
            end else begin
               check("blk_count", 32'(blk_count), 32'(exp_cnt_q.pop_front()));
               check("blk_ready_at_done", 32'(blk_ready), 32'd1);
               check("tready_at_done", 32'(s_axis_tready), 32'd0);
               for (int a = 0; a < BLK; a++) begin
                  rd_addr = 8'(a);
                  @(negedge clk);
                  if (a == 0) check("blk_done_width", 32'(blk_done), 32'd0);
                  e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hdead_beef;
                  check($sformatf("rd_data[%0d]", a), rd_data, e);
               end
               rd_addr = 8'd255;
               @(negedge clk);
               check("rd_out_of_range", rd_data, 32'd0);
               rd_addr = 8'd0;
            end
            rb_count++;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle();
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      clr_err       = 1'b0;
   endtask

   task automatic send_beat(input logic [31:0] d, input logic [1:0] u,
                            input logic l, input logic c);
      int g;
      if ($urandom_range(0, 7) == 0) begin
         @(negedge clk);
         s_axis_tvalid = 1'b0;
         clr_err       = 1'b0;
         repeat ($urandom_range(1, 3)) @(negedge clk);
      end else begin
         @(negedge clk);
      end
      s_axis_tdata  = d;
      s_axis_tuser  = u;
      s_axis_tlast  = l;
      clr_err       = c;
      s_axis_tvalid = 1'b1;
      g = 0;
      while (!s_axis_tready && g < 500) begin
         @(negedge clk);
         g++;
      end
      if (!s_axis_tready) begin
         check("tready_timeout", 32'(s_axis_tready), 32'd1);
         s_axis_tvalid = 1'b0;
         clr_err       = 1'b0;
         return;
      end
      @(posedge clk);
      model_beat(d, u, l, c);
   endtask

   // Sends a block; for error kinds the offending beat is at position pos
   // and the frame stops right after it.
   task automatic send_frame(input int kind, input int pos, input bit seq,
                             input logic [1:0] bad_x);
      logic [31:0] d;
      logic [1:0]  u;
      logic        l;
      bit          err;
      for (int p = 0; p < BLK; p++) begin
         d   = seq ? 32'(p) : $urandom();
         u   = 2'(p / PC);
         l   = (p % PC == PC - 1);
         err = 1'b0;
         if (p == pos) begin
            case (kind)
               K_CHAN:  begin u = u ^ bad_x; err = 1'b1; end
               K_EARLY: begin l = 1'b1;      err = 1'b1; end
               K_MISS:  begin l = 1'b0;      err = 1'b1; end
               default: err = 1'b0;
            endcase
         end
         send_beat(d, u, l, 1'b0);
         if (err) break;
      end
   endtask

   task automatic flush(input int n);
      for (int i = 0; i < n; i++) begin
         send_beat($urandom(), 2'($urandom_range(0, 3)), (i == n - 1), 1'b0);
      end
   endtask

   task automatic wait_rb();
      int g;
      g = 0;
      while (rb_count == rb_seen && g < 2000) begin
         @(negedge clk);
         g++;
      end
      check("readback_timeout", 32'(rb_count > rb_seen), 32'd1);
      rb_seen = rb_count;
   endtask

   task automatic release_blk();
      @(negedge clk);
      blk_release = 1'b1;
      @(negedge clk);
      blk_release = 1'b0;
      check("blk_ready_after_release", 32'(blk_ready), 32'd0);
      check("tready_after_release", 32'(s_axis_tready), 32'd1);
      m_full = 1'b0;
   endtask

   task automatic after_frame();
      idle();
      if (m_full) begin
         wait_rb();
         release_blk();
      end
   endtask

   task automatic check_errs(input string tag);
      check({tag, "_err_chan"}, 32'(err_chan), 32'(m_err_chan));
      check({tag, "_err_len"}, 32'(err_len), 32'(m_err_len));
   endtask

   task automatic clr_pulse();
      @(negedge clk);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err    = 1'b0;
      m_err_chan = 1'b0;
      m_err_len  = 1'b0;
      check_errs("clr");
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n       = 1'b0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      blk_release   = 1'b0;
      clr_err       = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tready", 32'(s_axis_tready), 32'd0);
      check("rst_blk_ready", 32'(blk_ready), 32'd0);
      check("rst_blk_done", 32'(blk_done), 32'd0);
      check("rst_err_chan", 32'(err_chan), 32'd0);
      check("rst_err_len", 32'(err_len), 32'd0);
      check("rst_blk_count", 32'(blk_count), 32'd0);
      check("rst_rd_data", rd_data, 32'd0);
      check("rst_state", 32'(dbg_state), 32'(RECV));
      cur_q.delete();
      exp_q.delete();
      exp_cnt_q.delete();
      m_discarding = 1'b0;
      m_full       = 1'b0;
      m_err_chan   = 1'b0;
      m_err_len    = 1'b0;
      m_count      = 0;
      reset_n = 1'b1;
      check("tready_at_reset_exit", 32'(s_axis_tready), 32'd0);
      @(negedge clk);
      check("tready_after_reset", 32'(s_axis_tready), 32'd1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int acc;
      int kind;
      int pos;
      int ch;
      do_reset();

      // Nominal block with tdata = beat index.
      send_frame(K_GOOD, -1, 1'b1, 2'b00);
      idle();
      wait_rb();

      // Backpressure: offer a beat while full, nothing may be taken.
      @(negedge clk);
      s_axis_tdata  = 32'h1234_5678;
      s_axis_tuser  = CH_Y;
      s_axis_tvalid = 1'b1;
      acc = 0;
      repeat (20) begin
         @(negedge clk);
         acc += int'(s_axis_tready);
      end
      check("bp_no_accept", 32'(acc), 32'd0);
      check("bp_blk_ready", 32'(blk_ready), 32'd1);
      s_axis_tvalid = 1'b0;
      release_blk();
      send_frame(K_GOOD, -1, 1'b0, 2'b00);
      after_frame();

      // Channel error on Y beat 10, then filler through tlast.
      send_frame(K_CHAN, 10, 1'b0, 2'b01);
      flush(53);
      idle();
      check_errs("chan");
      check("chan_state_recv", 32'(dbg_state), 32'(RECV));
      clr_pulse();
      send_frame(K_GOOD, -1, 1'b0, 2'b00);
      after_frame();

      // Early tlast on Y beat 30, then a new block overwrites the buffer.
      send_frame(K_EARLY, 30, 1'b0, 2'b00);
      idle();
      check_errs("early");
      check("early_state_recv", 32'(dbg_state), 32'(RECV));
      send_frame(K_GOOD, -1, 1'b0, 2'b00);
      after_frame();
      clr_pulse();

      // Missing tlast on Y beat 63, discard through the next tlast.
      send_frame(K_MISS, 63, 1'b0, 2'b00);
      idle();
      check("miss_state_discard", 32'(dbg_state), 32'(DISCARD));
      flush(5);
      idle();
      check_errs("miss");
      check("miss_state_recv", 32'(dbg_state), 32'(RECV));
      clr_pulse();
      // clr_err on the same edge as a new early-tlast error.
      send_beat($urandom(), CH_Y, 1'b1, 1'b1);
      idle();
      check_errs("clr_vs_set");
      send_frame(K_GOOD, -1, 1'b0, 2'b00);
      after_frame();

      // Random mix of good blocks and framing errors.
      for (int n = 0; n < 10; n++) begin
         kind = $urandom_range(0, 5);
         ch   = $urandom_range(0, 2);
         case (kind)
            3:       begin pos = $urandom_range(0, BLK - 1);     send_frame(K_CHAN, pos, 1'b0, 2'($urandom_range(1, 3))); end
            4:       begin pos = ch * PC + $urandom_range(0, PC - 2); send_frame(K_EARLY, pos, 1'b0, 2'b00); end
            5:       begin pos = ch * PC + PC - 1;               send_frame(K_MISS, pos, 1'b0, 2'b00); end
            default: send_frame(K_GOOD, -1, 1'b0, 2'b00);
         endcase
         if (m_discarding) flush($urandom_range(1, 5));
         after_frame();
         check_errs("rand");
         if ($urandom_range(0, 1) == 1) clr_pulse();
      end

      // Reset after 100 beats of a block, then a fresh block.
      for (int p = 0; p < 100; p++) begin
         send_beat($urandom(), 2'(p / PC), (p % PC == PC - 1), 1'b0);
      end
      do_reset();
      send_frame(K_GOOD, -1, 1'b0, 2'b00);
      after_frame();

      idle();
      check("pending_blocks", 32'(exp_cnt_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/jpeg_coeff_stream_sink.md
Name: jpeg_coeff_stream_sink

Overview:
- AXI-Stream consumer placed downstream of the JPEG compression pipeline output.
- Accepts the 32-bit coefficient stream tagged by tuser:
  - 00 = Y, 01 = Cb, 10 = Cr.
  - Each channel is PIXEL_COUNT beats, with tlast on the final beat of that channel.
- Checks framing and buffers one complete 8x8x3 block (Y, Cb, Cr).
- Exposes the buffered block to a DMA/PS-side reader through a registered read port, with backpressure until the block is released.

Parameters:
- DATA_WIDTH, 32, coefficient word width.
- DATA_DEPTH, 8, block edge length.
- PIXEL_COUNT, 64, beats per channel (DATA_DEPTH*DATA_DEPTH).
- ADDR_WIDTH, 8, buffer address width; must satisfy 2^ADDR_WIDTH >= 3*PIXEL_COUNT.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- s_axis_tdata  in  DATA_WIDTH  coefficient word
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  sink ready (registered)
- s_axis_tlast  in  1  last beat of the current channel
- s_axis_tuser  in  2  channel tag (00 Y, 01 Cb, 10 Cr)
- blk_ready  out  1  high while a complete block is held
- blk_done  out  1  one-cycle pulse when a block completes
- blk_release  in  1  reader frees the buffer (honoured only in FULL)
- rd_addr  in  ADDR_WIDTH  read address = ch*PIXEL_COUNT + idx
- rd_data  out  DATA_WIDTH  buffer word, one-cycle latency
- err_chan  out  1  sticky: wrong or illegal tuser seen
- err_len  out  1  sticky: tlast early, or missing on the PIXEL_COUNT-th beat
- clr_err  in  1  clears both sticky error flags
- blk_count  out  16  count of completed blocks, wraps at 65535

Behaviour:
- Reset: synchronous while reset_n=0.
  - Outputs: s_axis_tready=0, blk_ready=0, blk_done=0, err_chan=0, err_len=0, blk_count=0, rd_data=0.
  - Internal: state=RECV, expected channel ch=0, idx=0.
  - Buffer contents are not cleared.
  - s_axis_tready rises 1 cycle after reset_n goes high.
  - Reset mid-block discards all progress.
- Beat: accepted on a rising edge with tvalid && tready.
- tready: s_axis_tready <= (next_state != FULL). It is low in the cycle immediately after the final beat of the block is accepted.
- State RECV, on an accepted beat:
  - tuser != ch, or tuser == 11:
    - Set err_chan and drop the beat.
    - If tlast=1: stay in RECV with ch=0, idx=0.
    - Else: go to DISCARD.
  - tlast=1 with idx < PIXEL_COUNT-1:
    - Set err_len and drop the partial block.
    - ch=0, idx=0, stay in RECV.
  - idx == PIXEL_COUNT-1 with tlast=0:
    - Set err_len and go to DISCARD.
  - Otherwise write mem[ch*PIXEL_COUNT+idx] = tdata, then:
    - idx < PIXEL_COUNT-1: idx++.
    - idx == PIXEL_COUNT-1 and ch < 2: ch++, idx=0.
    - idx == PIXEL_COUNT-1 and ch == 2: go to FULL, pulse blk_done for 1 cycle, increment blk_count.
- State DISCARD:
  - tready=1; accepted beats are dropped.
  - The first accepted beat with tlast=1 returns to RECV with ch=0, idx=0.
  - That beat is also dropped, even if it is a correct-looking Y beat.
- State FULL:
  - blk_ready=1, tready=0.
  - blk_release=1 goes to RECV with ch=0, idx=0; blk_ready falls and tready rises on the next cycle.
  - blk_release outside FULL is ignored.
- Read port: rd_data <= mem[rd_addr] every cycle, in any state.
  - Data is meaningful only while blk_ready=1.
  - rd_addr >= 3*PIXEL_COUNT returns 0.
- Errors: flags are sticky until clr_err. If clr_err coincides with a new error, the flag ends up set (set wins).
- blk_done and blk_ready rise on the same edge.
- Memory: single write port, single synchronous read port; infers BRAM or LUTRAM.

Decomposition:
- Package jpeg_stream_pkg holds:
  - Channel tag constants CH_Y=2'b00, CH_CB=2'b01, CH_CR=2'b10.
  - State encodings RECV, DISCARD, FULL.
  - PIXEL_COUNT default.
- One natural sub-module: coeff_block_ram, a 1W/1R synchronous RAM of depth 3*PIXEL_COUNT and width DATA_WIDTH.
- Framing FSM and counters stay in the top module.

Test Plan:
- Nominal block, tready observed: send 192 beats with tdata = beat index 0..191, tuser 00/01/10 in order, tlast on beats 63, 127 and 191.
  - blk_done pulses once; blk_ready=1; blk_count=1.
  - rd_addr 0, 64, 191 return 0, 64, 191; s_axis_tready=0.
- Backpressure: hold tvalid=1 after the block completes with no release.
  - No beat is accepted while in FULL.
  - Pulse blk_release: tready=1 next cycle, and a second block completes giving blk_count=2.
- Channel error: 10 Y beats, then one beat with tuser=01 and tlast=0, then 53 filler beats ending in tlast.
  - err_chan=1, state returns to RECV.
  - A following good block completes normally.
- Early tlast: tlast on Y beat 30.
  - err_len=1, block dropped.
  - The next 192-beat block completes; mem[0] equals the new block's first word.
- Missing tlast: Y beat 63 sent with tlast=0.
  - err_len=1; beats are discarded up to and including the next tlast.
  - clr_err together with a new error leaves err_len=1.
- Reset mid-block after 100 beats:
  - All outputs zero, blk_count=0, tready=1 one cycle after release.
  - A fresh 192-beat block completes correctly.
